bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares the single FEPU→BEPU peripheral bus (address, write, write data, read data) between two masters: m0 = CPU, m1 = debug/loader port.
- Round-robin arbitration, one transaction at a time.
- Region-dependent wait states inserted before completion; one-cycle ack pulse to the winning master.
- Sits between the CPU/bus_controller pair and the BEPU peripherals (memory, LED, segment display).

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- WAIT_MEM, 0, extra access cycles when addr[AW-1]=0 (memory region).
- WAIT_IO, 2, extra access cycles when addr[AW-1]=1 (IO region: LED/segment).
- CW, 4, wait counter width; WAIT_MEM and WAIT_IO each ≤ 2^CW-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  CPU request; held high until m0_ack.
- m0_w  in  1  1=write, 0=read.
- m0_addr  in  AW  CPU address.
- m0_wdata  in  DW  CPU write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  DW  read data, valid in the m0_ack cycle, held until next m0 completion.
- m1_req, m1_w, m1_addr, m1_wdata, m1_ack, m1_rdata  (same widths and semantics as m0, for m1).
- bus_en  out  1  peripheral access strobe.
- bus_w  out  1  peripheral write enable.
- bus_addr  out  AW  peripheral address.
- bus_wdata  out  DW  peripheral write data.
- bus_rdata  in  DW  peripheral read data.
- grant  out  2  one-hot owner: 01=m0, 10=m1, 00=none.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- FSM states: IDLE, ACCESS, DONE.
- Reset values: state=IDLE; grant=00; bus_en=0; bus_w=0; bus_addr=0; bus_wdata=0; m0_ack=0; m1_ack=0; m0_rdata=0; m1_rdata=0; last_owner=m1 (so m0 wins the first tie).
- IDLE:
  - No req: stay.
  - Any req: select the winner; latch its w/addr/wdata into the bus registers; set grant; load the wait counter with WAIT_IO or WAIT_MEM (decoded from winner addr[AW-1]); go to ACCESS.
- Arbitration: single requester wins. If both request, the master that is not last_owner wins. last_owner updates on entry to ACCESS.
- ACCESS:
  - bus_en=1 and bus_w=latched w for every ACCESS cycle.
  - Bus address/data stay stable for the whole ACCESS period.
  - Counter==0: capture bus_rdata into the owner's rdata register (reads only; writes leave rdata unchanged); go to DONE.
  - Otherwise decrement the counter and stay.
- DONE:
  - bus_en=0, bus_w=0; owner's ack=1 for exactly this cycle; grant stays set.
  - Next cycle: IDLE, grant=00.
- Latency: req sampled in IDLE at edge N → ACCESS cycles N+1..N+1+WAIT → ack at cycle N+2+WAIT. Zero-wait transaction takes 3 cycles including IDLE.
- Back-to-back: a master that keeps req high after ack is rearbitrated in the IDLE cycle following DONE. It cannot hog the bus while the other master requests.
- Req drop mid-transaction: ignored. The transaction completes and ack still pulses.
- Input changes after latch: the owner's addr/w/wdata changes have no effect.
- Reset mid-operation: immediate abort to reset values. No ack is issued and bus_en drops in the cycle after the rst edge.
- Width: addr and data pass through unmodified. The counter never underflows.

Decomposition:
- Shared package bus_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), grant encodings (GNT_NONE, GNT_M0, GNT_M1), region-select bit index.
- bus_controller reuses the region-select bit index from bus_pkg.
- One sub-module, rr_arbiter2: combinational 2-way round-robin pick from req[1:0] and last_owner. Output is a one-hot winner.
- FSM, counter and datapath registers live in bus_arbiter.

Test Plan:
- Reset: hold rst high 2 cycles with both reqs high → all outputs 0, grant=00, no ack. Release → m0 granted first.
- m0 read, addr=0x0000_0010, WAIT_MEM=0, bus_rdata=0xDEAD_BEEF → bus_en high 1 cycle; m0_ack 2 cycles after the req-sample edge; m0_rdata=0xDEAD_BEEF.
- m1 write, addr=0x8000_0004, wdata=0x0000_00FF, WAIT_IO=2 → bus_en=bus_w=1 for exactly 3 cycles with stable addr/data; m1_ack pulses once; m1_rdata unchanged.
- Both masters hold req for 4 transactions, WAIT_MEM=0 → grant sequence 01,10,01,10; acks alternate; no overlap.
- m0 drops req in the 2nd ACCESS cycle of an IO access → access completes with 3 bus_en cycles; m0_ack still pulses.
- rst asserted in the middle ACCESS cycle of an IO write → next cycle bus_en=0, grant=00, no ack. A fresh m1 req after release completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared FSM encoding, grant codes and region decode for the
//                FEPU->BEPU peripheral bus.
//  Revision    : 1.0
// ============================================================================
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } bus_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    // The MSB of the address selects the IO region (LED/segment) over memory.
    function automatic int region_bit(input int aw);
        return aw - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Combinational two-way round-robin pick; one-hot winner.
//  Revision    : 1.0
// ============================================================================
module rr_arbiter2
    import bus_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = GNT_NONE;
        if (req_i == 2'b11) begin
            // On a tie the master that did not own the bus last time wins.
            gnt_o = (last_owner_i == OWNER_M1) ? GNT_M0 : GNT_M1;
        end else if (req_i[0]) begin
            gnt_o = GNT_M0;
        end else if (req_i[1]) begin
            gnt_o = GNT_M1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Round-robin arbiter sharing the peripheral bus between the
//                CPU (m0) and the debug/loader port (m1) with region waits.
//  Revision    : 1.0
// ============================================================================
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int WAIT_MEM = 0,
    parameter int WAIT_IO  = 2,
    parameter int CW       = 4
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_w,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_w,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          bus_en,
    output logic          bus_w,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    output logic [1:0]    grant
);

    localparam int RB = region_bit(AW);

    bus_state_t    state_q,  state_d;
    logic [1:0]    grant_q,  grant_d;
    logic          bus_en_q, bus_en_d;
    logic          bus_w_q,  bus_w_d;
    logic [AW-1:0] addr_q,   addr_d;
    logic [DW-1:0] wdata_q,  wdata_d;
    logic          ack0_q,   ack0_d;
    logic          ack1_q,   ack1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          last_q,   last_d;
    logic [CW-1:0] cnt_q,    cnt_d;

    logic [1:0]    win;
    logic          sel_w;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    rr_arbiter2 u_rr (
        .req_i        ({m1_req, m0_req}),
        .last_owner_i (last_q),
        .gnt_o        (win)
    );

    assign sel_w     = win[1] ? m1_w     : m0_w;
    assign sel_addr  = win[1] ? m1_addr  : m0_addr;
    assign sel_wdata = win[1] ? m1_wdata : m0_wdata;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        bus_en_d = bus_en_q;
        bus_w_d  = bus_w_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        last_d   = last_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (win != GNT_NONE) begin
                    grant_d  = win;
                    bus_en_d = 1'b1;
                    bus_w_d  = sel_w;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    cnt_d    = sel_addr[RB] ? CW'(WAIT_IO) : CW'(WAIT_MEM);
                    last_d   = win[1] ? OWNER_M1 : OWNER_M0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!bus_w_q) begin
                        if (grant_q == GNT_M1) rdata1_d = bus_rdata;
                        else                   rdata0_d = bus_rdata;
                    end
                    bus_en_d = 1'b0;
                    bus_w_d  = 1'b0;
                    ack0_d   = (grant_q == GNT_M0);
                    ack1_d   = (grant_q == GNT_M1);
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                grant_d = GNT_NONE;
                state_d = IDLE;
            end
            default: begin
                grant_d  = GNT_NONE;
                bus_en_d = 1'b0;
                bus_w_d  = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= GNT_NONE;
            bus_en_q <= 1'b0;
            bus_w_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            last_q   <= OWNER_M1;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            bus_en_q <= bus_en_d;
            bus_w_q  <= bus_w_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    assign grant     = grant_q;
    assign bus_en    = bus_en_q;
    assign bus_w     = bus_w_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign m0_ack    = ack0_q;
    assign m1_ack    = ack1_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Directed vector table plus corner-case sequences for
//                bus_arbiter (AW=DW=32, WAIT_MEM=0, WAIT_IO=2).
//  Revision    : 1.0
// ============================================================================
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_w, m1_req, m1_w;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        bus_en, bus_w;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [1:0]  grant;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.AW(32), .DW(32), .WAIT_MEM(0), .WAIT_IO(2), .CW(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_w(m0_w), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_w(m1_w), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .bus_en(bus_en), .bus_w(bus_w), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .grant(grant)
    );

    typedef struct {
        logic        rst;
        logic        r0;
        logic        r1;
        logic [31:0] brd;
        logic [1:0]  g;
        logic        en;
        logic        w;
        logic        k0;
        logic        k1;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } vec_t;

    vec_t        tbl [11];
    logic [1:0]  exp_g [4];
    int          n, en_cnt, ack_cnt;
    logic        seen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // rst r0 r1 brd | grant en w ack0 ack1 addr wdata rd0 rd1
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h0,        2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10,       32'h11111111, 32'h0,        32'h0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10,       32'h11111111, 32'hDEADBEEF, 32'h0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10,       32'h11111111, 32'hDEADBEEF, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h0,        2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80000004, 32'hFF,       32'hDEADBEEF, 32'h0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h12345678, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80000004, 32'hFF,       32'hDEADBEEF, 32'h0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h12345678, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80000004, 32'hFF,       32'hDEADBEEF, 32'h0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h12345678, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80000004, 32'hFF,       32'hDEADBEEF, 32'h0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000004, 32'hFF,       32'hDEADBEEF, 32'h0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000004, 32'hFF,       32'hDEADBEEF, 32'h0};

        rst = 1'b1;
        m0_req = 1'b0; m0_w = 1'b0; m0_addr = 32'h10;       m0_wdata = 32'h11111111;
        m1_req = 1'b0; m1_w = 1'b1; m1_addr = 32'h80000004; m1_wdata = 32'hFF;
        bus_rdata = 32'h0;

        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].rst; m0_req = tbl[i].r0; m1_req = tbl[i].r1; bus_rdata = tbl[i].brd;
            tick();
            chk($sformatf("v%0d_grant", i),  {30'd0, grant},  {30'd0, tbl[i].g});
            chk($sformatf("v%0d_bus_en", i), {31'd0, bus_en}, {31'd0, tbl[i].en});
            chk($sformatf("v%0d_bus_w", i),  {31'd0, bus_w},  {31'd0, tbl[i].w});
            chk($sformatf("v%0d_m0_ack", i), {31'd0, m0_ack}, {31'd0, tbl[i].k0});
            chk($sformatf("v%0d_m1_ack", i), {31'd0, m1_ack}, {31'd0, tbl[i].k1});
            chk($sformatf("v%0d_bus_addr", i),  bus_addr,  tbl[i].addr);
            chk($sformatf("v%0d_bus_wdata", i), bus_wdata, tbl[i].wd);
            chk($sformatf("v%0d_m0_rdata", i),  m0_rdata,  tbl[i].rd0);
            chk($sformatf("v%0d_m1_rdata", i),  m1_rdata,  tbl[i].rd1);
        end

        // Both masters saturate the bus: last owner was m1, so m0 goes first.
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        m0_addr = 32'h10; m0_w = 1'b0; m1_addr = 32'h20; m1_w = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            chk("rr_ack_overlap", {31'd0, m0_ack & m1_ack}, 32'd0);
            if (m0_ack || m1_ack) begin
                chk($sformatf("rr_grant%0d", n), {30'd0, grant}, {30'd0, exp_g[n]});
                chk($sformatf("rr_ack%0d", n), {30'd0, m1_ack, m0_ack}, {30'd0, exp_g[n]});
                n++;
                if (n == 4) begin
                    m0_req = 1'b0;
                    m1_req = 1'b0;
                end
            end
        end
        chk("rr_count", n, 4);
        tick(); tick();

        // m0 IO read; req drops and address changes during the 2nd ACCESS cycle.
        m0_addr = 32'h80000000; m0_w = 1'b0; bus_rdata = 32'hCAFE0001; m0_req = 1'b1;
        en_cnt = 0; ack_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus_en) begin
                en_cnt++;
                chk("drop_addr_stable", bus_addr, 32'h80000000);
            end
            if (m0_ack) begin
                ack_cnt++;
                chk("drop_m0_rdata", m0_rdata, 32'hCAFE0001);
            end
            if (c == 1) begin
                m0_req  = 1'b0;
                m0_addr = 32'h44;
            end
        end
        chk("drop_en_cycles", en_cnt, 3);
        chk("drop_ack_count", ack_cnt, 1);

        // Reset in the middle ACCESS cycle of an m1 IO write.
        m1_addr = 32'h80000008; m1_w = 1'b1; m1_wdata = 32'hAB; m1_req = 1'b1;
        tick();
        chk("rmid_en_first", {31'd0, bus_en}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        chk("rmid_bus_en", {31'd0, bus_en}, 32'd0);
        chk("rmid_grant", {30'd0, grant}, 32'd0);
        chk("rmid_m1_ack", {31'd0, m1_ack}, 32'd0);
        chk("rmid_bus_addr", bus_addr, 32'h0);
        chk("rmid_m0_rdata", m0_rdata, 32'h0);
        rst = 1'b0;
        m1_w = 1'b0; m1_addr = 32'h30; bus_rdata = 32'h5A5A5A5A;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            chk("post_m0_ack", {31'd0, m0_ack}, 32'd0);
            if (m1_ack) begin
                seen = 1'b1;
                m1_req = 1'b0;
                chk("post_m1_rdata", m1_rdata, 32'h5A5A5A5A);
                chk("post_grant", {30'd0, grant}, 32'd2);
            end
        end
        chk("post_ack_seen", {31'd0, seen}, 32'd1);
        tick();
        chk("post_idle_grant", {30'd0, grant}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
